// File: rtl/decode_ibuf.sv
`default_nettype none
// =============================================================================
// Module  : decode_ibuf
// Brief   : In-order instruction queue between the fetch->decode register and
//           the decoder; captures each FD bundle once, drops all on redirect.
// Revision: 1.0  initial release
// =============================================================================
module decode_ibuf #(
  parameter  int DEPTH       = 4,
  parameter  int INSTR_WIDTH = 32,
  parameter  int PC_WIDTH    = 32,
  parameter  int HIST_WIDTH  = 8,
  localparam int META_W      = HIST_WIDTH + 7,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   fd_valid_i,
  input  logic                   fetch_ready_i,
  input  logic [INSTR_WIDTH-1:0] fd_instr_i,
  input  logic [PC_WIDTH-1:0]    fd_pc_i,
  input  logic [PC_WIDTH-1:0]    fd_npc_i,
  input  logic [META_W-1:0]      fd_meta_i,
  output logic                   decode_allow_in_o,
  input  logic                   d_ready_i,
  output logic                   d_valid_o,
  output logic [INSTR_WIDTH-1:0] d_instr_o,
  output logic [PC_WIDTH-1:0]    d_pc_o,
  output logic [PC_WIDTH-1:0]    d_npc_o,
  output logic [META_W-1:0]      d_meta_o,
  output logic [CNT_W-1:0]       ibuf_count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = INSTR_WIDTH + 2 * PC_WIDTH + META_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_fd_new;

  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [CNT_W-1:0]   w_count_plus;
  logic [ENTRY_W-1:0] w_head;

  // An FD bundle is only a push candidate in the first cycle after it loads.
  assign w_push       = fd_valid_i & r_fd_new & ~flush_i;
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & d_ready_i & ~flush_i;
  // Room is reserved for the bundle pushed this cycle, so no decoder dependence.
  assign w_count_plus = r_count + CNT_W'(w_push);
  assign decode_allow_in_o = (w_count_plus < CNT_W'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fd_new <= 1'b0;
    end else begin
      r_fd_new <= decode_allow_in_o & fetch_ready_i;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= {fd_instr_i, fd_pc_i, fd_npc_i, fd_meta_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      assert (!(w_push && (r_count == CNT_W'(DEPTH))));
      assert (!(w_pop && (r_count == '0)));
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign d_valid_o    = w_valid;
  assign ibuf_count_o = r_count;
  assign {d_instr_o, d_pc_o, d_npc_o, d_meta_o} = w_valid ? w_head : '0;

endmodule
`default_nettype wire
